// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the AHB-Lite to APB bridge.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package apb_bridge_pkg;

  localparam int NSLOT = 9;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not.
  function automatic logic trans_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/apb_slot_decode.sv
// Maps the 4-bit address slot field to a one-hot APB select plus a mapped flag.
// Latency: purely combinational.
// Backpressure: none.
module apb_slot_decode #(
  parameter int NSLOT = 9
) (
  input  logic [3:0]       slot,
  output logic [NSLOT-1:0] onehot,
  output logic             valid
);
  import apb_bridge_pkg::*;

  // One bit per implemented slot; codes at or above NSLOT light nothing.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (slot == 4'(i)) onehot[i] = 1'b1;
    end
    valid = |onehot;
  end

endmodule

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave that turns single transfers into APB setup/access cycles on nine slots.
// Latency: read done 3 cycles after the address phase, write 4, plus one per PREADY=0 cycle.
// Backpressure: HREADYOUT held low for the whole APB transfer; unmapped slots give a two-cycle ERROR.
module ahb_apb_bridge #(
  parameter int ADDR_W   = 16,
  parameter int SLOT_LSB = 12,
  parameter int NSLOT    = 9
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [31:0]       HRDATA,
  output logic [NSLOT-1:0]  PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [31:0]       PWDATA,
  input  logic              PREADY,
  input  logic              PRESP,
  input  logic [31:0]       PRDATA
);
  import apb_bridge_pkg::*;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [NSLOT-1:0]  sel_q, sel_d;
  logic [31:0]       pwdata_q, pwdata_d;
  logic [31:0]       hrdata_q, hrdata_d;

  logic [3:0]        slot_in;
  logic [NSLOT-1:0]  slot_onehot;
  logic              slot_valid;
  logic              ready_state;
  logic              accept;
  logic              unused_ok;

  assign slot_in = HADDR[SLOT_LSB+3:SLOT_LSB];

  apb_slot_decode #(.NSLOT(NSLOT)) u_slot_decode (
    .slot   (slot_in),
    .onehot (slot_onehot),
    .valid  (slot_valid)
  );

  // Upper address bits and HTRANS[0] carry no meaning for this bridge.
  assign unused_ok = ^{HADDR, HTRANS};

  // States in which the bridge can take a new address phase.
  always_comb begin
    ready_state = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR2);
    accept      = HSEL & trans_active(HTRANS) & HREADY & ready_state;
  end

  // Next-state logic: decode on accept, then walk the APB setup/access sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (!accept)          state_d = ST_IDLE;
        else if (!slot_valid) state_d = ST_ERR1;
        else if (HWRITE)      state_d = ST_WDATA;
        else                  state_d = ST_SETUP;
      end
      ST_WDATA:  state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (PREADY) state_d = PRESP ? ST_ERR1 : ST_DONE;
      end
      ST_ERR1:   state_d = ST_ERR2;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath capture: address/direction/select on accept, write data in WDATA,
  // read data only on a clean completion so an errored read leaves HRDATA alone.
  always_comb begin
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    sel_d    = sel_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
    if (accept) begin
      paddr_d  = HADDR[ADDR_W-1:0];
      pwrite_d = HWRITE;
      sel_d    = slot_onehot;
    end
    if (state_q == ST_WDATA) pwdata_d = HWDATA;
    if ((state_q == ST_ACCESS) && PREADY && !PRESP && !pwrite_q) hrdata_d = PRDATA;
  end

  // State register.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers; reset clears every value that reaches an output.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      sel_q    <= '0;
      pwdata_q <= '0;
      hrdata_q <= '0;
    end else begin
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      sel_q    <= sel_d;
      pwdata_q <= pwdata_d;
      hrdata_q <= hrdata_d;
    end
  end

  // Output decode from state; PSEL is only driven during the APB phases.
  always_comb begin
    HREADYOUT = ready_state;
    HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
    PENABLE   = (state_q == ST_ACCESS);
    PSEL      = '0;
    if ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) PSEL = sel_q;
    PADDR     = paddr_q;
    PWRITE    = pwrite_q;
    PWDATA    = pwdata_q;
    HRDATA    = hrdata_q;
  end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Directed bench for ahb_apb_bridge with a completion scoreboard.
// Latency: checks exact completion cycle counts per transfer.
// Backpressure: drives PREADY wait states and error responses.
module tb_ahb_apb_bridge;
  import apb_bridge_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic [8:0]  PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [15:0] PADDR;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic        PRESP;
  logic [31:0] PRDATA;

  typedef struct {
    logic        resp;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [31:0] last_rd  = 32'h0;
  logic        psel_multi = 1'b0;

  always #5 HCLK = ~HCLK;

  ahb_apb_bridge #(.ADDR_W(16), .SLOT_LSB(12), .NSLOT(9)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PREADY    (PREADY),
    .PRESP     (PRESP),
    .PRDATA    (PRDATA)
  );

  // Flags any sampled cycle with more than one select bit.
  always @(negedge HCLK) begin
    if (!$onehot0(PSEL)) psel_multi <= 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge HCLK);
    cyc++;
  endtask

  // Presents an address phase in the current cycle (N) and returns at cycle N+1
  // with the bus idle and the write data placed in its data phase.
  task automatic start_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                            input logic exp_resp, input logic [31:0] exp_rdata, input int exp_lat);
    exp_t e;
    HSEL   = 1'b1;
    HTRANS = HTRANS_NONSEQ;
    HADDR  = addr;
    HWRITE = wr;
    e.resp = exp_resp; e.rdata = exp_rdata; e.lat = exp_lat;
    sb.push_back(e);
    cyc = 0;
    step();
    HSEL   = 1'b0;
    HTRANS = HTRANS_IDLE;
    HWDATA = wdata;
  endtask

  // Waits (bounded) for HREADYOUT, then checks latency and response against the scoreboard.
  task automatic finish_xfer(input string tag);
    exp_t e;
    while (HREADYOUT !== 1'b1 && cyc < 50) step();
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_lat"},   32'(cyc), 32'(e.lat));
      chk({tag, "_hready"}, {31'b0, HREADYOUT}, 32'h1);
      chk({tag, "_hresp"}, {31'b0, HRESP}, {31'b0, e.resp});
      chk({tag, "_hrdata"}, HRDATA, e.rdata);
    end
  endtask

  initial begin
    HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0;
    HWDATA = '0; HREADY = 1'b1; PREADY = 1'b1; PRESP = 1'b0; PRDATA = '0;

    // Reset values.
    step();
    chk("rst_hreadyout", {31'b0, HREADYOUT}, 32'h1);
    chk("rst_hresp",     {31'b0, HRESP}, 32'h0);
    chk("rst_hrdata",    HRDATA, 32'h0);
    chk("rst_psel",      {23'b0, PSEL}, 32'h0);
    chk("rst_penable",   {31'b0, PENABLE}, 32'h0);
    chk("rst_pwrite",    {31'b0, PWRITE}, 32'h0);
    chk("rst_paddr",     {16'b0, PADDR}, 32'h0);
    chk("rst_pwdata",    PWDATA, 32'h0);
    HRESET = 1'b0;
    step();

    // Transfers that must be ignored: BUSY, HSEL low, HREADY low.
    for (int i = 0; i < 3; i++) begin
      HADDR  = 32'h0000_3000;
      HWRITE = 1'b0;
      HSEL   = (i != 1);
      HTRANS = (i == 0) ? HTRANS_BUSY : HTRANS_NONSEQ;
      HREADY = (i != 2);
      step();
      HSEL = 1'b0; HTRANS = HTRANS_IDLE; HREADY = 1'b1;
      chk($sformatf("ign%0d_c1", i), {22'b0, HREADYOUT, PSEL}, 32'h200);
      step();
      chk($sformatf("ign%0d_c2", i), {22'b0, HREADYOUT, PSEL}, 32'h200);
    end

    // Zero-wait read from slot 3.
    PRDATA = 32'hDEADBEEF; PREADY = 1'b1; PRESP = 1'b0;
    start_xfer(32'h0000_3010, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF, 3);
    chk("rd3_setup_psel",    {23'b0, PSEL}, 32'h008);
    chk("rd3_setup_penable", {31'b0, PENABLE}, 32'h0);
    chk("rd3_setup_paddr",   {16'b0, PADDR}, 32'h3010);
    chk("rd3_setup_hready",  {31'b0, HREADYOUT}, 32'h0);
    step();
    chk("rd3_acc_psel",      {23'b0, PSEL}, 32'h008);
    chk("rd3_acc_penable",   {31'b0, PENABLE}, 32'h1);
    chk("rd3_acc_hrdata",    HRDATA, 32'h0);
    finish_xfer("rd3");
    chk("rd3_done_psel",     {23'b0, PSEL}, 32'h0);
    last_rd = 32'hDEADBEEF;

    // Write to slot 8 with three wait states.
    PREADY = 1'b0; PRDATA = 32'h1111_1111;
    start_xfer(32'h0000_8004, 1'b1, 32'h12345678, 1'b0, last_rd, 7);
    chk("wr8_wdata_psel",   {23'b0, PSEL}, 32'h0);
    chk("wr8_wdata_hready", {31'b0, HREADYOUT}, 32'h0);
    step();
    HWDATA = 32'hFFFF_0000;
    chk("wr8_setup_psel",   {23'b0, PSEL}, 32'h100);
    chk("wr8_setup_pwrite", {31'b0, PWRITE}, 32'h1);
    chk("wr8_setup_pwdata", PWDATA, 32'h12345678);
    chk("wr8_setup_paddr",  {16'b0, PADDR}, 32'h8004);
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 3) PREADY = 1'b1;
      chk($sformatf("wr8_acc%0d_psel", i),   {23'b0, PSEL}, 32'h100);
      chk($sformatf("wr8_acc%0d_pen", i),    {31'b0, PENABLE}, 32'h1);
      chk($sformatf("wr8_acc%0d_pwdata", i), PWDATA, 32'h12345678);
      chk($sformatf("wr8_acc%0d_paddr", i),  {16'b0, PADDR}, 32'h8004);
    end
    finish_xfer("wr8");

    // Read from slot 2 answered with an APB error.
    PREADY = 1'b1; PRESP = 1'b1; PRDATA = 32'hBAD0_BAD0;
    start_xfer(32'h0000_2000, 1'b0, 32'h0, 1'b1, last_rd, 4);
    chk("err2_setup_psel", {23'b0, PSEL}, 32'h004);
    step();
    chk("err2_acc_penable", {31'b0, PENABLE}, 32'h1);
    step();
    chk("err2_err1", {30'b0, HRESP, HREADYOUT}, 32'h2);
    finish_xfer("err2");
    PRESP = 1'b0;
    step();
    chk("err2_after_hresp", {31'b0, HRESP}, 32'h0);

    // Unmapped slot 0xA.
    start_xfer(32'h0000_A000, 1'b0, 32'h0, 1'b1, last_rd, 2);
    chk("unm_err1",      {30'b0, HRESP, HREADYOUT}, 32'h2);
    chk("unm_err1_psel", {23'b0, PSEL}, 32'h0);
    finish_xfer("unm");
    chk("unm_err2_psel", {23'b0, PSEL}, 32'h0);
    step();

    // Back-to-back read slot 0 then write slot 1 issued in the DONE cycle.
    PRDATA = 32'h0BAD_F00D;
    start_xfer(32'h0000_0040, 1'b0, 32'h0, 1'b0, 32'h0BAD_F00D, 3);
    chk("b2b_rd_setup_psel", {23'b0, PSEL}, 32'h001);
    step();
    chk("b2b_rd_acc_psel", {23'b0, PSEL}, 32'h001);
    finish_xfer("b2b_rd");
    last_rd = 32'h0BAD_F00D;
    chk("b2b_done_psel", {23'b0, PSEL}, 32'h0);
    start_xfer(32'h0000_1008, 1'b1, 32'hCAFE_F00D, 1'b0, last_rd, 4);
    chk("b2b_wdata_psel", {23'b0, PSEL}, 32'h0);
    step();
    chk("b2b_wr_setup_psel", {23'b0, PSEL}, 32'h002);
    chk("b2b_wr_pwdata", PWDATA, 32'hCAFE_F00D);
    step();
    chk("b2b_wr_acc_psel", {23'b0, PSEL}, 32'h002);
    finish_xfer("b2b_wr");
    chk("psel_onehot", {31'b0, psel_multi}, 32'h0);

    // Reset asserted while in ACCESS, then a normal read.
    PREADY = 1'b0;
    start_xfer(32'h0000_5000, 1'b0, 32'h0, 1'b0, 32'h0, 3);
    step();
    chk("rstm_acc_psel", {23'b0, PSEL}, 32'h020);
    HRESET = 1'b1;
    #1;
    chk("rstm_psel",    {23'b0, PSEL}, 32'h0);
    chk("rstm_penable", {31'b0, PENABLE}, 32'h0);
    chk("rstm_hready",  {31'b0, HREADYOUT}, 32'h1);
    chk("rstm_hrdata",  HRDATA, 32'h0);
    sb.delete();
    step();
    HRESET = 1'b0;
    last_rd = 32'h0;
    step();
    chk("rstm_idle_psel", {23'b0, PSEL}, 32'h0);
    PREADY = 1'b1; PRDATA = 32'h55AA_33CC;
    start_xfer(32'h0000_4ABC, 1'b0, 32'h0, 1'b0, 32'h55AA_33CC, 3);
    chk("post_rst_psel",  {23'b0, PSEL}, 32'h010);
    chk("post_rst_paddr", {16'b0, PADDR}, 32'h4ABC);
    finish_xfer("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
